uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and mid-bit
// sampling. Each completed byte is held in data/valid until the consumer acks.
// A byte that lands while the previous one is unread sets the sticky overrun
// flag. A bad stop bit pulses frame_err. A held-low line (break) is reported
// once and is not retriggered until the line has been seen idle again.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic [7:0]       data_nx;
  logic             valid_nx, overrun_nx, frame_err_nx;
  logic             armed, armed_nx;

  // Synchronizer stages: rx_p0 is the metastability catcher, rx_s the clean copy.
  logic             rx_p0, rx_s;
  // primed[1] goes high once both synchronizer flops hold real line samples
  // instead of their reset value, so a line that is low across a reset
  // release is not mistaken for idle.
  logic [1:0]       primed;

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0  <= 1'b1;
      rx_s   <= 1'b1;
      primed <= 2'b00;
    end else begin
      rx_p0  <= rx;
      rx_s   <= rx_p0;
      primed <= {primed[0], 1'b1};
    end
  end

  // Next-state logic: frame sequencing, bit sampling and result flags.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    idx_nx       = idx;
    shift_nx     = shift;
    armed_nx     = armed;
    data_nx      = data;
    valid_nx     = valid & ~ack;
    overrun_nx   = overrun;
    frame_err_nx = 1'b0;

    case (state)
      IDLE: begin
        if (rx_s) begin
          if (primed[1]) armed_nx = 1'b1;
        end else if (armed) begin
          state_nx = START;
          cnt_nx   = '0;
          armed_nx = 1'b0;
        end
      end

      START: begin
        if (cnt == CNT_HALF_END) begin
          cnt_nx = '0;
          if (!rx_s) begin
            state_nx = DATA;
            idx_nx   = 3'd0;
          end else begin
            // Start bit did not survive to its mid-point: a glitch, drop it.
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt == CNT_BIT_END) begin
          shift_nx[idx] = rx_s;
          cnt_nx        = '0;
          if (idx == 3'd7) state_nx = STOP;
          else             idx_nx   = idx + 3'd1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt == CNT_BIT_END) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          if (rx_s) begin
            // New byte wins over a coincident ack; only an unacked byte overruns.
            data_nx  = shift;
            valid_nx = 1'b1;
            if (valid && !ack) overrun_nx = 1'b1;
          end else begin
            frame_err_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      armed     <= 1'b0;
      data      <= 8'h00;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      shift     <= shift_nx;
      armed     <= armed_nx;
      data      <= data_nx;
      valid     <= valid_nx;
      overrun   <= overrun_nx;
      frame_err <= frame_err_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed test of uart_rx at CLK_FREQ=16, BAUD=1 (16 clocks/bit).
module tb_uart_rx;

  localparam int BIT  = 16;
  localparam int HALF = 8;
  // 2 synchronizer edges + IDLE->START edge + HALF + 9*BIT
  localparam int LAT  = 3 + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, overrun, frame_err, busy;

  uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .ack      (ack),
    .data     (data),
    .valid    (valid),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts valid rising edges and frame_err high cycles.
  int   n_rise = 0;
  int   n_fe   = 0;
  int   rise_cyc = 0;
  logic valid_q = 1'b0;
  always @(negedge clk) begin
    if (valid && !valid_q) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    valid_q <= valid;
    if (frame_err) n_fe <= n_fe + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_period(input logic v);
    rx = v;
    tick(BIT);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    ack = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  initial begin
    int b_rise, b_fe, lat, hi;

    tick(1);

    // Reset state
    do_reset();
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    tick(4);

    // Single byte, latency, ack behaviour
    b_rise = n_rise; b_fe = n_fe;
    send(8'hA5, 1'b1);
    lat = rise_cyc - start_cyc;
    chk("a5_data", data, 8'hA5);
    chk("a5_valid", valid, 1'b1);
    chk("a5_rises", n_rise - b_rise, 1);
    chk("a5_no_fe", n_fe - b_fe, 0);
    if (!(lat >= LAT - 2 && lat <= LAT)) $display("latency measured %0d cycles", lat);
    chk("a5_latency_window", (lat >= LAT - 2 && lat <= LAT), 1'b1);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("ack_clears_valid", valid, 1'b0);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("idle_ack_valid", valid, 1'b0);
    chk("idle_ack_data", data, 8'hA5);
    chk("idle_ack_overrun", overrun, 1'b0);

    // Handshake and overrun
    do_reset(); tick(4);
    send(8'h3C, 1'b1);
    tick(BIT);
    send(8'hC3, 1'b1);
    chk("ovr_data", data, 8'hC3);
    chk("ovr_valid", valid, 1'b1);
    chk("ovr_overrun", overrun, 1'b1);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("ovr_ack_valid", valid, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);

    // Framing error, then recovery
    do_reset(); tick(4);
    b_rise = n_rise; b_fe = n_fe;
    send(8'h55, 1'b0);
    chk("fe_pulse_count", n_fe - b_fe, 1);
    chk("fe_valid", valid, 1'b0);
    chk("fe_data", data, 8'h00);
    chk("fe_no_rise", n_rise - b_rise, 0);
    tick(BIT);
    send(8'h01, 1'b1);
    chk("fe_recover_data", data, 8'h01);
    chk("fe_recover_valid", valid, 1'b1);

    // Break: line held low for many frames
    do_reset(); tick(4);
    b_rise = n_rise; b_fe = n_fe;
    rx = 1'b0;
    tick(BIT * 14);
    chk("brk_fe_once", n_fe - b_fe, 1);
    chk("brk_not_busy", busy, 1'b0);
    chk("brk_no_rise", n_rise - b_rise, 0);
    rx = 1'b1;
    tick(BIT);

    // Glitch: short low pulse
    do_reset(); tick(4);
    b_rise = n_rise; b_fe = n_fe;
    hi = 0;
    rx = 1'b0; tick(3); rx = 1'b1;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) hi++;
      tick(1);
    end
    if (!(hi > 0 && hi <= HALF + 1)) $display("glitch busy cycles %0d", hi);
    chk("glitch_busy_len", (hi > 0 && hi <= HALF + 1), 1'b1);
    chk("glitch_idle", busy, 1'b0);
    chk("glitch_no_valid", n_rise - b_rise, 0);
    chk("glitch_no_fe", n_fe - b_fe, 0);

    // Back-to-back frames, ack coincident with second completion
    do_reset(); tick(4);
    fork
      begin
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
      end
      begin
        tick(10 * BIT + LAT - 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
      end
    join
    chk("b2b_data", data, 8'hFF);
    chk("b2b_valid", valid, 1'b1);
    chk("b2b_overrun", overrun, 1'b0);

    // Reset during bit 4 of a frame
    do_reset(); tick(4);
    fork
      send(8'h81, 1'b1);
      begin
        tick(BIT * 5 + HALF);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
      end
    join
    b_rise = n_rise; b_fe = n_fe;
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_data", data, 8'h00);
    send(8'h7E, 1'b1);
    chk("midrst_rises", n_rise - b_rise, 1);
    chk("midrst_data_7e", data, 8'h7E);
    chk("midrst_no_fe", n_fe - b_fe, 0);
    chk("midrst_overrun", overrun, 1'b0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
